fifo_ctrl: RTL and testbench

Control and sequencing block for the RAM_memory datapath. It turns requester push/pop requests into RAM write/read enables and wr_ptr/rd_ptr addresses. It tracks occupancy, drives full/empty/almost_full/almost_empty status and flags overflow/underflow. It sits between the upstream/downstream logic and RAM_memory; RAM data lines pass around this block.

---
 rtl/fifo_ctrl_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 24 ++
 rtl/fifo_ctrl.sv | 143 ++++++++++++++
 tb/tb_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: FSM state encoding and sizing helpers.
package fifo_ctrl_pkg;

    localparam int unsigned FIFO_ADDR_SIZE_DEF = 6;

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_ERROR  = 2'b10
    } fifo_state_e;

    function automatic int unsigned fifo_depth(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address counter; advances by one on inc and rolls over at DEPTH.
module fifo_ptr #(
    parameter int ADDR_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 inc,
    output logic [ADDR_SIZE-1:0] ptr
);

    logic [ADDR_SIZE-1:0] ptr_r;

    // Pointer register; natural overflow of the ADDR_SIZE vector gives the wrap.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_r <= {ADDR_SIZE{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + ADDR_SIZE'(1);
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control/sequencing for RAM_memory: push/pop acceptance, RAM enables and
// addresses, occupancy tracking, status flags and sticky overflow/underflow error.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 6,
    parameter int CNT_SIZE  = ADDR_SIZE + 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ADDR_SIZE-1:0] umbral_alto,
    input  logic [ADDR_SIZE-1:0] umbral_bajo,
    output logic                 write,
    output logic                 read,
    output logic [ADDR_SIZE-1:0] wr_ptr,
    output logic [ADDR_SIZE-1:0] rd_ptr,
    output logic                 valid_out,
    output logic [CNT_SIZE-1:0]  count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_error
);

    localparam logic [CNT_SIZE-1:0] DEPTH_C = CNT_SIZE'(fifo_depth(ADDR_SIZE));

    fifo_state_e          state_r, state_s;
    logic [ADDR_SIZE-1:0] alto_r, alto_s;
    logic [ADDR_SIZE-1:0] bajo_r, bajo_s;
    logic [CNT_SIZE-1:0]  count_r, count_s;
    logic                 push_acc_s, pop_acc_s, ovf_s, unf_s;
    logic                 full_r, empty_r, af_r, ae_r;
    logic                 full_s, empty_s, af_s, ae_s;
    logic                 valid_r, error_r;

    // Next-state and request acceptance; a rejected half of a request is what trips ERROR.
    always_comb begin
        state_s    = state_r;
        alto_s     = alto_r;
        bajo_s     = bajo_r;
        push_acc_s = 1'b0;
        pop_acc_s  = 1'b0;
        ovf_s      = 1'b0;
        unf_s      = 1'b0;
        case (state_r)
            ST_INIT: begin
                alto_s  = umbral_alto;
                bajo_s  = umbral_bajo;
                state_s = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                push_acc_s = push & ~full_r;
                pop_acc_s  = pop & ~empty_r;
                ovf_s      = push & full_r;
                unf_s      = pop & empty_r;
                if (ovf_s || unf_s) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                state_s = ST_ERROR;
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Next occupancy and the flags derived from it, so flags land together with count.
    always_comb begin
        count_s = count_r;
        if (push_acc_s && !pop_acc_s) begin
            count_s = count_r + CNT_SIZE'(1);
        end else if (pop_acc_s && !push_acc_s) begin
            count_s = count_r - CNT_SIZE'(1);
        end else begin
            count_s = count_r;
        end
        full_s  = (count_s == DEPTH_C);
        empty_s = (count_s == {CNT_SIZE{1'b0}});
        af_s    = (count_s >= CNT_SIZE'(alto_s));
        ae_s    = (count_s <= CNT_SIZE'(bajo_s));
    end

    // Control state, thresholds, occupancy and registered status.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= ST_INIT;
            alto_r  <= {ADDR_SIZE{1'b0}};
            bajo_r  <= {ADDR_SIZE{1'b0}};
            count_r <= {CNT_SIZE{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
            valid_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_s;
            alto_r  <= alto_s;
            bajo_r  <= bajo_s;
            count_r <= count_s;
            valid_r <= pop_acc_s;
            error_r <= error_r | ovf_s | unf_s;
            if (state_r != ST_ERROR) begin
                full_r  <= full_s;
                empty_r <= empty_s;
                af_r    <= af_s;
                ae_r    <= ae_s;
            end
        end
    end

    fifo_ptr #(.ADDR_SIZE(ADDR_SIZE)) u_wr_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (push_acc_s),
        .ptr     (wr_ptr)
    );

    fifo_ptr #(.ADDR_SIZE(ADDR_SIZE)) u_rd_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (pop_acc_s),
        .ptr     (rd_ptr)
    );

    assign write        = push_acc_s;
    assign read         = pop_acc_s;
    assign count        = count_r;
    assign valid_out    = valid_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign fifo_error   = error_r;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: queue-based reference model compared every
// negedge, directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       push, pop;
    logic [5:0] umbral_alto, umbral_bajo;
    logic       write, read, valid_out, full, empty, almost_full, almost_empty, fifo_error;
    logic [5:0] wr_ptr, rd_ptr;
    logic [6:0] count;

    fifo_ctrl #(.ADDR_SIZE(6), .CNT_SIZE(7)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .pop          (pop),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .write        (write),
        .read         (read),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .valid_out    (valid_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = waiting for first clock after reset, 1 = running, 2 = halted.
    int m_phase   = 0;
    int m_q[$];
    int m_wr_tot  = 0;
    int m_rd_tot  = 0;
    int m_alto    = 0;
    int m_bajo    = 0;
    bit m_err     = 1'b0;
    bit m_valid   = 1'b0;
    bit m_flags   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every clock edge and immediately on reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge reset_L);
            if (!reset_L) begin
                m_phase = 0; m_q.delete(); m_wr_tot = 0; m_rd_tot = 0;
                m_alto = 0; m_bajo = 0; m_err = 1'b0; m_valid = 1'b0; m_flags = 1'b0;
            end else if (m_phase == 0) begin
                m_alto = int'(umbral_alto); m_bajo = int'(umbral_bajo);
                m_phase = 1; m_flags = 1'b1; m_valid = 1'b0;
            end else if (m_phase == 1) begin
                automatic int  n  = m_q.size();
                automatic bit  pa = push && (n < 64);
                automatic bit  qa = pop && (n > 0);
                if (qa) begin
                    void'(m_q.pop_front());
                    m_rd_tot++;
                end
                if (pa) begin
                    m_q.push_back(m_wr_tot % 64);
                    m_wr_tot++;
                end
                m_valid = qa;
                if ((push && n == 64) || (pop && n == 0)) begin
                    m_err = 1'b1;
                    m_phase = 2;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare every output against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            begin
                automatic int n   = m_q.size();
                automatic bit act = (m_phase == 1) && reset_L;
                automatic bit e_w = act && push && (n < 64);
                automatic bit e_r = act && pop && (n > 0);
                check("write", write, e_w);
                check("read", read, e_r);
                check("wr_ptr", wr_ptr, m_wr_tot % 64);
                check("rd_ptr", rd_ptr, m_rd_tot % 64);
                check("count", count, n);
                check("valid_out", valid_out, m_valid);
                check("fifo_error", fifo_error, m_err);
                check("full", full, m_flags ? (n == 64) : 0);
                check("empty", empty, m_flags ? (n == 0) : 1);
                check("almost_full", almost_full, m_flags ? (n >= m_alto) : 0);
                check("almost_empty", almost_empty, m_flags ? (n <= m_bajo) : 1);
                if (e_r && read) check("rd_order", rd_ptr, m_q[0]);
            end
        end
    end

    task automatic cyc(input bit p, input bit q);
        @(posedge clk);
        #1;
        push = p;
        pop  = q;
        @(negedge clk);
    endtask

    task automatic do_reset(input int alto, input int bajo);
        @(posedge clk);
        #1;
        reset_L = 1'b0; push = 1'b0; pop = 1'b0;
        umbral_alto = 6'(alto); umbral_bajo = 6'(bajo);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        reset_L = 1'b0; push = 1'b1; pop = 1'b0;
        umbral_alto = 6'd60; umbral_bajo = 6'd4;
        repeat (2) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_afull", almost_full, 0);
        check("rst_write", write, 0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        @(negedge clk);
        check("init_write_ignored", write, 0);
        cyc(1'b0, 1'b0);
        check("post_init_count", count, 0);
        check("post_init_empty", empty, 1);

        // 64 pushes with threshold crossings
        for (int i = 1; i <= 64; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 5) check("ae_at4", almost_empty, 1);
            if (i == 6) check("ae_at5", almost_empty, 0);
            if (i == 60) check("af_at59", almost_full, 0);
            if (i == 61) check("af_at60", almost_full, 1);
        end
        cyc(1'b0, 1'b0);
        check("fill_count", count, 64);
        check("fill_full", full, 1);
        check("fill_wrptr_wrap", wr_ptr, 0);
        check("fill_err", fifo_error, 0);

        // Steady-state push&pop at count 10
        do_reset(60, 4);
        repeat (10) cyc(1'b1, 1'b0);
        repeat (20) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        check("pp_count", count, 10);
        check("pp_wrptr", wr_ptr, 30);
        check("pp_rdptr", rd_ptr, 20);
        check("pp_valid", valid_out, 1);

        // Overflow while full with simultaneous pop
        do_reset(60, 4);
        repeat (64) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("ovf_read", read, 1);
        check("ovf_write", write, 0);
        cyc(1'b0, 1'b0);
        check("ovf_count", count, 63);
        check("ovf_err", fifo_error, 1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("err_write", write, 0);
        check("err_read", read, 0);
        check("err_count", count, 63);
        check("err_rdptr", rd_ptr, 1);

        // Underflow: pop alone, then push&pop on empty
        do_reset(60, 4);
        cyc(1'b0, 1'b1);
        check("unf_read", read, 0);
        cyc(1'b0, 1'b0);
        check("unf_err", fifo_error, 1);
        do_reset(60, 4);
        cyc(1'b1, 1'b1);
        check("unf_pp_write", write, 1);
        check("unf_pp_read", read, 0);
        cyc(1'b0, 1'b0);
        check("unf_pp_count", count, 1);
        check("unf_pp_err", fifo_error, 1);

        // Asynchronous reset mid-cycle
        do_reset(60, 4);
        repeat (20) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("pre_async_count", count, 20);
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_wrptr", wr_ptr, 0);
        check("async_rdptr", rd_ptr, 0);
        check("async_empty", empty, 1);
        check("async_err", fifo_error, 0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        push = 1'b1;
        @(negedge clk);
        check("async_init_write", write, 0);
        cyc(1'b1, 1'b0);
        check("async_active_write", write, 1);
        cyc(1'b0, 1'b0);
        check("async_post_count", count, 1);

        // Randomized traffic with varied thresholds
        for (int seg = 0; seg < 8; seg++) begin
            automatic int alto  = (seg == 0) ? 0 : int'($urandom_range(0, 63));
            automatic int bajo  = (seg == 1) ? 63 : int'($urandom_range(0, 63));
            automatic int ppush = int'($urandom_range(20, 80));
            automatic int ppop  = int'($urandom_range(20, 80));
            do_reset(alto, bajo);
            for (int c = 0; c < 250; c++) begin
                automatic bit p = ($urandom_range(0, 99) < ppush) &&
                                  (m_q.size() < 63 || $urandom_range(0, 39) == 0);
                automatic bit q = ($urandom_range(0, 99) < ppop) &&
                                  (m_q.size() > 1 || $urandom_range(0, 39) == 0);
                cyc(p, q);
            end
        end
        cyc(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
